// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle shifter for the ALU shift path.
// Takes a WIDTH-bit operand, a SHAMT_W-bit amount and an op (SLL/SRL/SRA/ROTR),
// moves one bit per clock (two with SHIFTSEQ_DUALSTEP_EN), then pulses Done.
// Ports: Clk, Rst (async, active-high), Start, Op[1:0], Shamt, Operand in;
//        Busy (SHIFT or DONE), Done (1-cycle), Result (held until next op) out.
// Build option: `define SHIFTSEQ_DUALSTEP_EN to shift two positions per edge.
module shift_sequencer #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Start,
    input  logic [1:0]         Op,
    input  logic [SHAMT_W-1:0] Shamt,
    input  logic [WIDTH-1:0]   Operand,
    output logic               Busy,
    output logic               Done,
    output logic [WIDTH-1:0]   Result
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTR = 2'b11;

    state_t             state_q;
    state_t             state_d;
    logic [WIDTH-1:0]   work_q;
    logic [WIDTH-1:0]   work_nxt;
    logic [WIDTH-1:0]   result_q;
    logic [SHAMT_W-1:0] count_q;
    logic [SHAMT_W-1:0] count_nxt;
    logic [1:0]         op_q;

    function automatic logic [WIDTH-1:0] shift1(
        input logic [WIDTH-1:0] w,
        input logic [1:0]       op
    );
        logic [WIDTH-1:0] r;
        case (op)
            OP_SLL:  r = {w[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, w[WIDTH-1:1]};
            OP_SRA:  r = {w[WIDTH-1], w[WIDTH-1:1]};
            OP_ROTR: r = {w[0], w[WIDTH-1:1]};
            default: r = w;
        endcase
        return r;
    endfunction

    // One SHIFT-state step: next work value and remaining count.
    always_comb begin
        work_nxt  = shift1(work_q, op_q);
        count_nxt = count_q - SHAMT_W'(1);
`ifdef SHIFTSEQ_DUALSTEP_EN
        // Two positions while at least two remain; a final odd bit goes alone.
        if (count_q >= SHAMT_W'(2)) begin
            work_nxt  = shift1(shift1(work_q, op_q), op_q);
            count_nxt = count_q - SHAMT_W'(2);
        end
`endif
    end

    // State register
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    state_d = (Shamt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                if (count_nxt == '0) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath; Result is written only on the edge that enters DONE.
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            work_q   <= '0;
            count_q  <= '0;
            op_q     <= OP_SLL;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (Start) begin
                        work_q  <= Operand;
                        count_q <= Shamt;
                        op_q    <= Op;
                        if (Shamt == '0) begin
                            result_q <= Operand;
                        end
                    end
                end
                SHIFT: begin
                    work_q  <= work_nxt;
                    count_q <= count_nxt;
                    if (count_nxt == '0) begin
                        result_q <= work_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs
    always_comb begin
        Busy = (state_q == SHIFT) || (state_q == DONE);
        Done = (state_q == DONE);
    end

    assign Result = result_q;

endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: directed vectors with a result/timing scoreboard.
// Driver pushes expected results; a negedge monitor pops on each Done pulse.
module tb_shift_sequencer;

    localparam logic [1:0] SLL  = 2'b00;
    localparam logic [1:0] SRL  = 2'b01;
    localparam logic [1:0] SRA  = 2'b10;
    localparam logic [1:0] ROTR = 2'b11;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Start = 1'b0;
    logic [1:0]  Op = 2'b00;
    logic [4:0]  Shamt = 5'd0;
    logic [31:0] Operand = 32'd0;
    logic        Busy;
    logic        Done;
    logic [31:0] Result;

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          at;
        string       nm;
    } exp_t;

    exp_t sb[$];

    shift_sequencer #(.WIDTH(32), .SHAMT_W(5)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Start   (Start),
        .Op      (Op),
        .Shamt   (Shamt),
        .Operand (Operand),
        .Busy    (Busy),
        .Done    (Done),
        .Result  (Result)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    function automatic int lat(input logic [4:0] sh);
`ifdef SHIFTSEQ_DUALSTEP_EN
        return (int'(sh) + 1) / 2 + 1;
`else
        return int'(sh) + 1;
`endif
    endfunction

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    endtask

    // Scoreboard monitor
    always @(negedge Clk) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                total_cnt++;
                $display("FAIL spurious_done: Done=1 at cycle %0d, expected none",
                         cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check({e.nm, "_result"}, Result, e.res);
                check({e.nm, "_done_cycle"}, 32'(cyc), 32'(e.at));
                check({e.nm, "_busy_in_done"}, {31'd0, Busy}, 32'd1);
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [4:0] sh,
                            input logic [31:0] opd, input logic [31:0] res,
                            input string nm, input bit expect_done);
        @(negedge Clk);
        Op = op;
        Shamt = sh;
        Operand = opd;
        Start = 1'b1;
        if (expect_done) sb.push_back('{res, cyc + lat(sh), nm});
        @(negedge Clk);
        Start = 1'b0;
        // Inputs after capture must not disturb the operation
        Operand = $urandom;
        Op = 2'($urandom);
        Shamt = 5'($urandom);
        check({nm, "_busy"}, {31'd0, Busy}, 32'd1);
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 80; i++) begin
            if (sb.size() == 0) break;
            @(negedge Clk);
        end
        check({nm, "_timeout"}, 32'(sb.size()), 32'd0);
        sb.delete();
        @(negedge Clk);
    endtask

    task automatic run(input logic [1:0] op, input logic [4:0] sh,
                       input logic [31:0] opd, input logic [31:0] res,
                       input string nm);
        start_op(op, sh, opd, res, nm, 1'b1);
        wait_idle(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge Clk);
        check("reset_busy", {31'd0, Busy}, 32'd0);
        check("reset_done", {31'd0, Done}, 32'd0);
        check("reset_result", Result, 32'd0);
        Rst = 1'b0;

        run(SLL, 5'd31, 32'h0000_0001, 32'h8000_0000, "sll31");
        run(SRA, 5'd4, 32'h8000_0000, 32'hF800_0000, "sra4");
        run(SRL, 5'd4, 32'h8000_0000, 32'h0800_0000, "srl4");
        run(ROTR, 5'd1, 32'h0000_0001, 32'h8000_0000, "rotr1");
        run(ROTR, 5'd8, 32'h1234_5678, 32'h7812_3456, "rotr8");
        run(SRA, 5'd3, 32'h7FFF_FFF0, 32'h0FFF_FFFE, "sra3_pos");
        run(ROTR, 5'd31, 32'h8000_0001, 32'h0000_0003, "rotr31");
        run(SRA, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "sra31");
        run(SRL, 5'd31, 32'h8000_0000, 32'h0000_0001, "srl31");
        run(ROTR, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "rotr0");

        // Zero shift: Busy for exactly one cycle
        start_op(SLL, 5'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, "sll0", 1'b1);
        @(negedge Clk);
        check("sll0_busy_one_cycle", {31'd0, Busy}, 32'd0);
        wait_idle("sll0");
        check("sll0_result_held", Result, 32'hDEAD_BEEF);

        // Start while busy is ignored
        start_op(SLL, 5'd10, 32'h0000_0001, 32'h0000_0400, "ignore", 1'b1);
        @(negedge Clk);
        Op = SRL;
        Shamt = 5'd1;
        Operand = 32'hFFFF_FFFF;
        Start = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        check("ignore_busy", {31'd0, Busy}, 32'd1);
        wait_idle("ignore");
        repeat (4) @(negedge Clk);
        check("ignore_result_held", Result, 32'h0000_0400);

        // Reset in mid-operation aborts with no Done
        start_op(SLL, 5'd20, 32'h0000_0001, 32'h0, "abort", 1'b0);
        repeat (4) @(negedge Clk);
        Rst = 1'b1;
        #1;
        check("abort_busy", {31'd0, Busy}, 32'd0);
        check("abort_done", {31'd0, Done}, 32'd0);
        check("abort_result", Result, 32'd0);
        @(negedge Clk);
        Rst = 1'b0;
        repeat (25) @(negedge Clk);
        check("abort_idle_busy", {31'd0, Busy}, 32'd0);
        run(SLL, 5'd2, 32'h0000_0001, 32'h0000_0004, "after_abort");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/shift_sequencer.md
Name: shift_sequencer

Overview:
- Multi-cycle barrel-shift replacement for the ALU shift path.
- Accepts a 32-bit operand and a 5-bit shift amount (instruction shamt field or rs[4:0]). Shifts one bit position per clock under a small FSM.
- Sits beside the ALU. The main controller drives Start and stalls the pipeline while Busy is high.
- The shift amount is always unsigned, 0..31.

Parameters:
- WIDTH, 32, operand and result width in bits.
- SHAMT_W, 5, shift-amount width. WIDTH must equal 2**SHAMT_W.

Ports:
- Clk  input  1  system clock; all state updates on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  request; sampled only in IDLE.
- Op  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR; captured with Start.
- Shamt  input  SHAMT_W  unsigned shift amount; captured with Start.
- Operand  input  WIDTH  value to shift; captured with Start.
- Busy  output  1  high in SHIFT and DONE states.
- Done  output  1  one-cycle pulse; Result is valid while it is high.
- Result  output  WIDTH  shifted value; held until the next accepted Start.

Behaviour:
- Interface: one clock (Clk). Reset (Rst) is asynchronous and active-high.
- Reset values: state=IDLE, Busy=0, Done=0, Result=0, internal count=0, op register=00.
- FSM states: IDLE, SHIFT, DONE.
- IDLE, Start=1 at an edge:
  - Load the work register with Operand, count with Shamt, and the op register with Op.
  - Go to SHIFT if Shamt != 0, else go to DONE.
- IDLE, Start=0: hold. Result keeps its last value.
- SHIFT, each edge: shift the work register by one position per the op register, decrement count. Go to DONE when count reaches 0 (count was 1 before the edge).
- Per-step shift rules:
  - SLL: insert 0 at the LSB.
  - SRL: insert 0 at the MSB.
  - SRA: replicate the MSB.
  - ROTR: old bit 0 moves to bit WIDTH-1.
- DONE: Done=1 and Result=work register, for exactly one cycle, then IDLE at the next edge.
- Latency: Done is high in the cycle after the (Shamt+1)th rising edge, counting the edge that samples Start as edge 1. Shamt=0 gives latency 1 and Result=Operand for every Op.
- Start while Busy=1 (SHIFT or DONE) is ignored; no queuing. Back-to-back throughput is one request per Shamt+2 cycles.
- Operand, Shamt and Op may change freely after capture without affecting an operation in flight.
- Result updates only on entry to DONE. Between operations it holds the last completed value.
- Rst asserted mid-operation: immediately returns to IDLE with all outputs at reset values. No Done pulse for the aborted request.
- Rst deasserted: the first Start can be sampled on the first following rising edge.
- Op=11 with Shamt=0: Result=Operand. Rotation by any Shamt is mod WIDTH.

Optional Feature:
- Macro: SHIFTSEQ_DUALSTEP_EN.
- Defined:
  - In SHIFT, shift by 2 positions per edge and decrement count by 2 while count>=2. Shift by 1 when count==1.
  - Latency = ceil(Shamt/2)+1 edges. Result values are identical to the single-step build.
- Not defined: one position per edge as above.

Test Plan:
- Reset, then SLL Operand=0x00000001 Shamt=31 -> Busy high; Done pulses once after 32 edges; Result=0x80000000.
- SRA Operand=0x80000000 Shamt=4 -> Result=0xF8000000 after 5 edges. SRL with the same inputs -> Result=0x08000000.
- ROTR Operand=0x00000001 Shamt=1 -> Result=0x80000000, Done after 2 edges. ROTR 0x12345678 Shamt=8 -> Result=0x78123456.
- Shamt=0, SLL Operand=0xDEADBEEF -> Done after 1 edge, Result=0xDEADBEEF. Busy high for exactly 1 cycle.
- Start SLL 0x1 Shamt=10, pulse Start again with SRL 0xFFFFFFFF at edge 3 -> second request ignored. Result=0x00000400, single Done.
- Start SLL 0x1 Shamt=20, assert Rst at edge 6 -> Busy=0, Done=0, Result=0 immediately. No Done appears. A following Shamt=2 request yields 0x00000004 after 3 edges.
